// File: rtl/div32_seq.sv
// Sequential 32-bit RV32M divider (DIV/DIVU/REM/REMU) using restoring radix-2 division.
// Latency: done pulses 34 edges after the start edge; start is ignored unless the block is idle.

// Trial-subtraction adder: {cout, sum} = x + y + sub.
module adder32 (
  input  logic [31:0] x,
  input  logic [31:0] y,
  input  logic        sub,
  output logic [31:0] sum,
  output logic        cout
);
  assign {cout, sum} = {1'b0, x} + {1'b0, y} + {32'b0, sub};
endmodule

module div32_seq (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        done,
  output logic [31:0] result
);
  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t      state;
  logic [1:0]  op_q;
  logic [31:0] a_q;
  logic [31:0] b_q;
  logic [31:0] b_mag;
  logic        sign_a;
  logic        sign_b;
  logic [31:0] rem_q;
  logic [31:0] quo_q;
  logic [4:0]  cnt;

  logic        signed_op;
  logic [32:0] shifted;
  logic [31:0] diff;
  logic        cout;
  logic        sub_ok;
  logic [31:0] fix_res;

  assign signed_op = ~op[0];

  // quo_q starts as |a| and shifts out dividend bits while quotient bits shift in.
  assign shifted = {rem_q, quo_q[31]};

  adder32 u_sub (
    .x   (shifted[31:0]),
    .y   (~b_mag),
    .sub (1'b1),
    .sum (diff),
    .cout(cout)
  );

  assign sub_ok = shifted[32] | cout;

  always_comb begin
    fix_res = 32'h0;
    if (b_q == 32'h0) begin
      fix_res = op_q[1] ? a_q : 32'hFFFF_FFFF;
    end else if (!op_q[1]) begin
      // -2^31 / -1 yields quo=0x80000000 with no sign flip, matching RV32M overflow.
      fix_res = (sign_a ^ sign_b) ? (32'h0 - quo_q) : quo_q;
    end else begin
      fix_res = sign_a ? (32'h0 - rem_q) : rem_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      busy   <= 1'b0;
      done   <= 1'b0;
      result <= 32'h0;
      op_q   <= 2'b00;
      a_q    <= 32'h0;
      b_q    <= 32'h0;
      b_mag  <= 32'h0;
      sign_a <= 1'b0;
      sign_b <= 1'b0;
      rem_q  <= 32'h0;
      quo_q  <= 32'h0;
      cnt    <= 5'd0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            state  <= CALC;
            busy   <= 1'b1;
            op_q   <= op;
            a_q    <= a;
            b_q    <= b;
            sign_a <= signed_op & a[31];
            sign_b <= signed_op & b[31];
            quo_q  <= (signed_op & a[31]) ? (32'h0 - a) : a;
            b_mag  <= (signed_op & b[31]) ? (32'h0 - b) : b;
            rem_q  <= 32'h0;
            cnt    <= 5'd0;
          end
        end
        CALC: begin
          rem_q <= sub_ok ? diff : shifted[31:0];
          quo_q <= {quo_q[30:0], sub_ok};
          cnt   <= cnt + 5'd1;
          if (cnt == 5'd31) state <= FIX;
        end
        FIX: begin
          result <= fix_res;
          busy   <= 1'b0;
          done   <= 1'b1;
          state  <= DONE;
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_div32_seq.sv
// Randomized and directed bench for div32_seq against an arithmetic RV32M reference.
module tb_div32_seq;
  logic        clk;
  logic        rst_n;
  logic        start;
  logic [1:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic [31:0] result;

  int checks   = 0;
  int failures = 0;

  div32_seq dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .op    (op),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .result(result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    int  sx;
    int  sy;
    logic ovf;
    sx  = x;
    sy  = y;
    ovf = (x == 32'h8000_0000) && (y == 32'hFFFF_FFFF);
    case (o)
      2'b00: begin
        if (y == 0) return 32'hFFFF_FFFF;
        if (ovf) return 32'h8000_0000;
        return 32'(sx / sy);
      end
      2'b01: return (y == 0) ? 32'hFFFF_FFFF : x / y;
      2'b10: begin
        if (y == 0) return x;
        if (ovf) return 32'h0;
        return 32'(sx % sy);
      end
      default: return (y == 0) ? x : x % y;
    endcase
  endfunction

  // Called at a negedge with the DUT idle; returns at the negedge where done is seen.
  task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] x,
                        input logic [31:0] y, input int inject);
    logic [31:0] expv;
    int n;
    int busy_err;
    bit seen;
    expv     = ref_model(o, x, y);
    busy_err = 0;
    seen     = 0;
    start = 1'b1; op = o; a = x; b = y;
    @(posedge clk);
    n = 1;
    for (int g = 0; g < 100; g++) begin
      @(negedge clk);
      start = (n == inject);
      op = 2'($urandom); a = $urandom; b = $urandom;
      if (done) begin
        seen = 1;
        break;
      end
      if (!busy) busy_err++;
      @(posedge clk);
      n++;
    end
    start = 1'b0;
    check({tag, "_done_seen"}, 32'(seen), 32'd1);
    check({tag, "_latency"}, n, 34);
    check({tag, "_busy_inflight"}, busy_err, 0);
    check({tag, "_busy_at_done"}, 32'(busy), 32'd0);
    check({tag, "_result"}, result, expv);
  endtask

  initial begin
    logic [31:0] ra;
    logic [31:0] rb;
    logic [31:0] held;
    int          stray;
    rst_n = 1'b0; start = 1'b0; op = 2'b00; a = 32'h0; b = 32'h0;
    repeat (2) @(negedge clk);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_result", result, 32'h0);
    rst_n = 1'b1;
    @(negedge clk);

    run_op("divu_100_7", 2'b01, 32'd100, 32'd7, 0);
    @(negedge clk);
    check("done_single_pulse", 32'(done), 32'd0);
    held = result;
    repeat (3) @(negedge clk);
    check("result_holds", result, held);
    run_op("remu_100_7", 2'b11, 32'd100, 32'd7, 0);

    // start during the done cycle is dropped; a start in the next (idle) cycle is taken
    start = 1'b1; op = 2'b01; a = 32'd5; b = 32'd1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    check("start_in_done_ignored", 32'(busy), 32'd0);
    run_op("div_m100_7", 2'b00, 32'hFFFF_FF9C, 32'd7, 0);
    @(negedge clk);
    run_op("rem_m100_7", 2'b10, 32'hFFFF_FF9C, 32'd7, 0);
    @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      run_op("div_by_zero", 2'(k), 32'h1234_5678, 32'h0, 0);
      @(negedge clk);
    end
    run_op("div_ovf", 2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    @(negedge clk);
    run_op("rem_ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    @(negedge clk);
    run_op("start_in_calc", 2'b00, 32'hDEAD_BEEF, 32'h0000_1234, 10);
    @(negedge clk);
    check("no_queued_op", 32'(busy), 32'd0);

    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 9))
        0:       rb = 32'h0;
        1:       rb = 32'h1;
        2:       rb = 32'hFFFF_FFFF;
        3:       rb = $urandom_range(1, 15);
        default: rb = $urandom;
      endcase
      ra = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : $urandom;
      run_op("rand", 2'($urandom), ra, rb, 0);
      @(negedge clk);
    end

    // abort mid-CALC with a nonzero result held from the last operation
    run_op("pre_abort", 2'b01, 32'hFFFF_FFFF, 32'd3, 0);
    @(negedge clk);
    start = 1'b1; op = 2'b01; a = 32'd1000; b = 32'd3;
    @(posedge clk);
    for (int n = 1; n < 20; n++) begin
      @(negedge clk);
      start = 1'b0;
      @(posedge clk);
    end
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_result", result, 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    stray = 0;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (done || busy) stray++;
    end
    check("abort_no_done", stray, 0);
    run_op("divu_after_reset", 2'b01, 32'hFFFF_FFFF, 32'd1, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/div32_seq.md
DIV32_SEQ -- requirements
Module: div32_seq

Interface
REQ-001 The block SHALL have no parameters; the datapath width is fixed at 32 bits.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 start  input  1  request; sampled only in IDLE.
REQ-005 op  input  2  operation: 00 DIV, 01 DIVU, 10 REM, 11 REMU (RV32M semantics).
REQ-006 a  input  32  dividend.
REQ-007 b  input  32  divisor.
REQ-008 busy  output  1  high while an operation is in flight (CALC or FIX state).
REQ-009 done  output  1  one-cycle pulse; result valid in that cycle.
REQ-010 result  output  32  quotient (DIV/DIVU) or remainder (REM/REMU); holds until the next accepted start.

Function
REQ-011 The state machine SHALL have states IDLE, CALC, FIX and DONE, all registered.
REQ-012 Transitions SHALL be:
- IDLE -> CALC on a clock edge with start=1.
- CALC -> FIX after the 32nd iteration.
- FIX -> DONE.
- DONE -> IDLE unconditionally.
REQ-013 On acceptance, op, a and b SHALL be latched, together with the operand signs (signed ops only) and the operand magnitudes; later input changes SHALL have no effect on the operation.
REQ-014 CALC SHALL run a restoring radix-2 division over exactly 32 cycles, using one new quotient bit per cycle, MSB first, through a 5-bit iteration counter that counts 0..31.
REQ-015 Each trial subtraction SHALL use one instance of the team's Adder32:
- Inputs: x = low 32 bits of the shifted partial remainder, y = ~divisor magnitude, sub=1.
- The subtraction succeeds when bit 32 of the shifted remainder is 1 or cout is 1.
- On success, the remainder takes the difference and the quotient bit is 1; otherwise the remainder is restored and the quotient bit is 0.
REQ-016 For DIV, FIX SHALL negate the quotient when sign(a) XOR sign(b) is 1.
REQ-017 For REM, FIX SHALL give the remainder the sign of a. DIVU/REMU SHALL not be sign-corrected.
REQ-018 When b=0, FIX SHALL force the result to 0xFFFFFFFF for DIV/DIVU and to the original a for REM/REMU. Latency SHALL be unchanged.
REQ-019 For DIV with a=0x80000000 and b=0xFFFFFFFF, the result SHALL be 0x80000000. For REM with the same operands, the result SHALL be 0x00000000.
REQ-020 Latency: done SHALL be high in the cycle that follows the 34th rising edge counted from the edge that sampled start. That is one acceptance edge, 32 CALC edges and 1 FIX edge.
REQ-021 busy SHALL be 1 from the cycle after acceptance through the FIX cycle. busy SHALL be 0 in DONE and in IDLE. done and busy SHALL never be high together.
REQ-022 start asserted while busy=1 or done=1 SHALL be ignored, without queuing.
REQ-023 result SHALL be updated only at the FIX->DONE edge. Back-to-back operations SHALL be possible, with start accepted in the first IDLE cycle after done.

Reset
REQ-024 When rst_n=0, the block SHALL asynchronously force: state=IDLE, busy=0, done=0, result=0x00000000, iteration counter=0, and internal remainder and quotient registers to 0.
REQ-025 Reset asserted mid-operation SHALL abort it. No done pulse SHALL follow, and the next start after rst_n rises SHALL be accepted normally.

Verification
REQ-026 DIVU a=100, b=7 -> done at the 34th edge after start, result=14. REMU with the same operands -> result=2.
REQ-027 DIV a=0xFFFFFF9C (-100), b=7 -> result=0xFFFFFFF2 (-14). REM with the same operands -> result=0xFFFFFFFE (-2).
REQ-028 b=0 with a=0x12345678:
- DIV and DIVU -> result=0xFFFFFFFF.
- REM and REMU -> result=0x12345678.
- Latency is 34 edges in every case.
REQ-029 DIV a=0x80000000, b=0xFFFFFFFF -> result=0x80000000. REM with the same operands -> result=0x00000000.
REQ-030 start pulsed again in CALC cycle 10, with a and b changed after acceptance -> ignored, and the result matches the originally latched operands.
REQ-031 rst_n driven low in CALC cycle 20 -> busy, done and result read 0 immediately, with no done pulse afterwards. After rst_n rises, DIVU 0xFFFFFFFF/1 -> result=0xFFFFFFFF.
